// File: rtl/npc_pkg.sv
// ============================================================================
// Module   : npc_pkg
// Purpose  : Shared types and constants for the NPC core fetch path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    EXEC  = 2'd3
  } fetch_state_t;

  localparam logic [63:0] NPC_RESET_PC = 64'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/npc_fetch_seq.sv
// ============================================================================
// Module   : npc_fetch_seq
// Purpose  : PC owner and single-in-flight fetch sequencer with retire count.
//            Optional misaligned-fetch trap: NPC_FETCH_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_fetch_seq
  import npc_pkg::*;
#(
  parameter logic [63:0] RESET_PC = NPC_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        misalign,
  output logic [63:0] instret
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [31:0]  r_inst;
  logic [63:0]  r_inst_pc;
  logic         r_misalign;
  logic [63:0]  r_instret;
  logic         w_misaligned;

`ifdef NPC_FETCH_MISALIGN_TRAP_EN
  assign w_misaligned = |r_pc[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  // A misaligned PC never reaches memory; it is turned into a marker instead.
  assign imem_req   = (r_state == FETCH) & rst_n & ~w_misaligned;
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == HOLD) & rst_n;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign misalign   = r_misalign;
  assign instret    = r_instret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_inst     <= 32'd0;
      r_inst_pc  <= 64'd0;
      r_misalign <= 1'b0;
      r_instret  <= 64'd0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_misaligned) begin
            r_inst     <= 32'd0;
            r_inst_pc  <= r_pc;
            r_misalign <= 1'b1;
            r_state    <= HOLD;
          end else if (imem_gnt && imem_rvalid) begin
            r_inst     <= imem_rdata;
            r_inst_pc  <= r_pc;
            r_misalign <= 1'b0;
            r_state    <= HOLD;
          end else if (imem_gnt) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_inst     <= imem_rdata;
            r_inst_pc  <= r_pc;
            r_misalign <= 1'b0;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (redirect_valid) begin
            r_pc      <= redirect_pc;
            r_instret <= r_instret + 64'd1;
            r_state   <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
